// File: rtl/cmd_dispatch_pkg.sv
// Shared types and constants for the command dispatcher: FSM encodings,
// the flush opcode, default response bytes and the pending-counter update.
package cmd_dispatch_pkg;

   typedef enum logic [1:0] {E_IDLE, E_ISSUE, E_BUSY} exec_state_t;
   typedef enum logic       {R_IDLE, R_WAIT}          resp_state_t;

   localparam logic [3:0] OPC_FLUSH    = 4'h0;
   localparam logic [7:0] ACK_BYTE_DEF = 8'hA5;
   localparam logic [7:0] NAK_BYTE_DEF = 8'h5A;

   // Saturating 3-bit pending count; up to two increments can land in one cycle
   function automatic logic [2:0] pend_next(input logic [2:0] cur,
                                            input logic [1:0] inc,
                                            input logic       dec);
      logic [3:0] sum;
      sum = {1'b0, cur} + {2'b00, inc} - {3'b000, dec};
      return (sum > 4'd7) ? 3'd7 : sum[2:0];
   endfunction

endpackage

// File: rtl/cmd_dispatch_fifo.sv
// Small command FIFO with a combinational head; flush wins over push/pop.
module cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic                     i_flush,
   input  logic [WIDTH-1:0]         i_din,
   output logic [WIDTH-1:0]         o_dout,
   output logic [$clog2(DEPTH):0]   o_cnt,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int             AW       = $clog2(DEPTH);
   localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [AW:0]      r_cnt;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_cnt == FULL_CNT);
   assign o_empty = (r_cnt == '0);
   assign o_cnt   = r_cnt;
   assign o_dout  = r_mem[r_rd];
   assign w_push  = i_push & ~o_full & ~i_flush;
   assign w_pop   = i_pop & ~o_empty & ~i_flush;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= i_din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else if (i_flush) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop)  r_rd <= r_rd + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/cmd_dispatch.sv
// Command dispatcher: takes commands from the UART wrapper, queues them, issues
// them one at a time to the execution engine and returns ACK/NAK bytes.
module cmd_dispatch
   import cmd_dispatch_pkg::*;
#(
   parameter int         DEPTH    = 4,
   parameter logic [7:0] ACK_BYTE = ACK_BYTE_DEF,
   parameter logic [7:0] NAK_BYTE = NAK_BYTE_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [15:0]            i_cmd,
   input  logic                   i_cmd_rdy,
   output logic                   o_clr_cmd_rdy,
   output logic [15:0]            o_exe_cmd,
   output logic                   o_exe_vld,
   input  logic                   i_exe_rdy,
   input  logic                   i_exe_done,
   output logic                   o_trmt,
   output logic [7:0]             o_resp,
   input  logic                   i_tx_done,
   output logic [$clog2(DEPTH):0] o_q_cnt
);

   exec_state_t r_est;
   resp_state_t r_rstate;
   logic        r_clr_q;
   logic [15:0] r_exe_cmd;
   logic        r_exe_vld;
   logic        r_trmt;
   logic [7:0]  r_resp;
   logic [2:0]  r_ack_pend;
   logic [2:0]  r_nak_pend;

   logic        w_take;
   logic        w_is_flush;
   logic        w_flush;
   logic        w_push;
   logic        w_drop;
   logic        w_pop;
   logic        w_done;
   logic [1:0]  w_ack_inc;
   logic        w_ack_dec;
   logic        w_nak_dec;
   logic [15:0] w_head;
   logic        w_full;
   logic        w_empty;

   // The registered copy keeps the consume pulse to one cycle while the wrapper drops cmd_rdy
   assign w_take        = i_cmd_rdy & ~r_clr_q;
   assign o_clr_cmd_rdy = w_take;

   assign w_is_flush = (i_cmd[15:12] == OPC_FLUSH);
   assign w_flush    = w_take & w_is_flush;
   assign w_push     = w_take & ~w_is_flush & ~w_full;
   assign w_drop     = w_take & ~w_is_flush & w_full;
   assign w_pop      = (r_est == E_ISSUE) & i_exe_rdy & ~w_flush;
   assign w_done     = (r_est == E_BUSY) & i_exe_done;

   assign w_ack_inc  = {1'b0, w_done} + {1'b0, w_flush};
   assign w_ack_dec  = (r_rstate == R_IDLE) & (r_ack_pend != 3'd0);
   assign w_nak_dec  = (r_rstate == R_IDLE) & (r_ack_pend == 3'd0) & (r_nak_pend != 3'd0);

   assign o_exe_cmd = r_exe_cmd;
   assign o_exe_vld = r_exe_vld;
   assign o_trmt    = r_trmt;
   assign o_resp    = r_resp;

   cmd_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .i_din   (i_cmd),
      .o_dout  (w_head),
      .o_cnt   (o_q_cnt),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_clr_q <= 1'b0;
      else        r_clr_q <= w_take;
   end

   // A flush during E_ISSUE discards the presented command without an ACK
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_est     <= E_IDLE;
         r_exe_vld <= 1'b0;
         r_exe_cmd <= '0;
      end else begin
         case (r_est)
            E_IDLE: begin
               if (!w_empty && !w_flush) begin
                  r_est     <= E_ISSUE;
                  r_exe_cmd <= w_head;
                  r_exe_vld <= 1'b1;
               end
            end
            E_ISSUE: begin
               if (w_flush) begin
                  r_est     <= E_IDLE;
                  r_exe_vld <= 1'b0;
               end else if (i_exe_rdy) begin
                  r_est     <= E_BUSY;
                  r_exe_vld <= 1'b0;
               end
            end
            E_BUSY: begin
               if (i_exe_done) r_est <= E_IDLE;
            end
            default: begin
               r_est     <= E_IDLE;
               r_exe_vld <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rstate <= R_IDLE;
         r_trmt   <= 1'b0;
         r_resp   <= '0;
      end else begin
         r_trmt <= 1'b0;
         case (r_rstate)
            R_IDLE: begin
               if (w_ack_dec) begin
                  r_resp   <= ACK_BYTE;
                  r_trmt   <= 1'b1;
                  r_rstate <= R_WAIT;
               end else if (w_nak_dec) begin
                  r_resp   <= NAK_BYTE;
                  r_trmt   <= 1'b1;
                  r_rstate <= R_WAIT;
               end
            end
            R_WAIT: begin
               if (i_tx_done) r_rstate <= R_IDLE;
            end
            default: r_rstate <= R_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ack_pend <= '0;
         r_nak_pend <= '0;
      end else begin
         r_ack_pend <= pend_next(r_ack_pend, w_ack_inc, w_ack_dec);
         r_nak_pend <= pend_next(r_nak_pend, {1'b0, w_drop}, w_nak_dec);
      end
   end

endmodule

// File: tb/tb_cmd_dispatch.sv
// Directed + randomized bench for cmd_dispatch with a queue-based reference
// model of the FIFO contents, plus bench-side engine and transmitter responders.
module tb_cmd_dispatch;

   localparam int DEPTH = 4;
   localparam logic [7:0] ACK = 8'hA5;
   localparam logic [7:0] NAK = 8'h5A;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] i_cmd;
   logic        i_cmd_rdy;
   logic        o_clr_cmd_rdy;
   logic [15:0] o_exe_cmd;
   logic        o_exe_vld;
   logic        i_exe_rdy;
   logic        i_exe_done;
   logic        o_trmt;
   logic [7:0]  o_resp;
   logic        i_tx_done;
   logic [2:0]  o_q_cnt;

   cmd_dispatch #(.DEPTH(DEPTH), .ACK_BYTE(8'hA5), .NAK_BYTE(8'h5A)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_cmd         (i_cmd),
      .i_cmd_rdy     (i_cmd_rdy),
      .o_clr_cmd_rdy (o_clr_cmd_rdy),
      .o_exe_cmd     (o_exe_cmd),
      .o_exe_vld     (o_exe_vld),
      .i_exe_rdy     (i_exe_rdy),
      .i_exe_done    (i_exe_done),
      .o_trmt        (o_trmt),
      .o_resp        (o_resp),
      .i_tx_done     (i_tx_done),
      .o_q_cnt       (o_q_cnt)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   logic [15:0] exp_fifo[$];
   logic [15:0] issued[$];
   logic [15:0] pushed_ord[$];
   logic [7:0]  got[$];
   int          n_push, n_drop;

   bit          clr_prev, eng_busy, eng_start, tx_busy;
   int          eng_cnt, tx_cnt;
   logic [7:0]  tx_resp;
   int          rdy_mode;
   bit          done_en, tx_hold;
   int          done_max, tx_max;

   task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
      n_chk++;
      assert (got_v === exp_v)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got_v, exp_v);
      end
   endtask

   // One clock: check and update the model at the falling edge, then drive
   // the engine/transmitter responders just after the rising edge.
   task automatic tick();
      bit exp_clr, hs, full_pre;
      @(negedge clk);
      exp_clr = i_cmd_rdy && !clr_prev;
      chk("clr_cmd_rdy", o_clr_cmd_rdy, exp_clr);
      clr_prev = exp_clr;
      chk("q_cnt", o_q_cnt, exp_fifo.size());
      if (o_exe_vld) begin
         if (exp_fifo.size() == 0) chk("exe_vld_empty", o_exe_vld, 0);
         else                      chk("exe_cmd_head", o_exe_cmd, exp_fifo[0]);
      end
      if (o_trmt) begin
         chk("trmt_gap", tx_busy, 0);
         got.push_back(o_resp);
      end else if (tx_busy) begin
         chk("resp_stable", o_resp, tx_resp);
      end
      if (i_tx_done) tx_busy = 0;
      if (o_trmt) begin
         tx_busy = 1;
         tx_resp = o_resp;
         tx_cnt  = $urandom_range(tx_max, 0);
      end
      hs       = (o_exe_vld === 1'b1) && i_exe_rdy;
      full_pre = (exp_fifo.size() == DEPTH);
      if (hs) begin
         issued.push_back(o_exe_cmd);
         if (exp_fifo.size() > 0) void'(exp_fifo.pop_front());
         eng_start = 1;
      end
      if (exp_clr) begin
         if (i_cmd[15:12] == 4'h0) exp_fifo.delete();
         else if (full_pre) n_drop++;
         else begin
            exp_fifo.push_back(i_cmd);
            pushed_ord.push_back(i_cmd);
            n_push++;
         end
      end
      if (i_exe_done) eng_busy = 0;
      @(posedge clk);
      #1;
      i_exe_done = 1'b0;
      if (eng_start) begin
         eng_start = 0;
         eng_busy  = 1;
         eng_cnt   = $urandom_range(done_max, 0);
      end else if (eng_busy && done_en) begin
         if (eng_cnt == 0) i_exe_done = 1'b1;
         else              eng_cnt--;
      end
      i_exe_rdy = (rdy_mode == 2) ? 1'($urandom_range(1, 0)) : (rdy_mode == 1);
      i_tx_done = 1'b0;
      if (tx_busy && !tx_hold) begin
         if (tx_cnt == 0) i_tx_done = 1'b1;
         else             tx_cnt--;
      end
   endtask

   task automatic send(input logic [15:0] c, input int gap);
      i_cmd     = c;
      i_cmd_rdy = 1'b1;
      tick();
      i_cmd_rdy = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic wait_resp(input int k, input int budget, input string tag);
      int t = 0;
      while (got.size() < k && t < budget) begin
         tick();
         t++;
      end
      chk(tag, got.size(), k);
   endtask

   task automatic clear_logs();
      got.delete();
      issued.delete();
      pushed_ord.delete();
      n_push = 0;
      n_drop = 0;
   endtask

   initial begin
      int na5, n5a;
      rst_n = 1'b0; i_cmd = '0; i_cmd_rdy = 1'b0; i_exe_rdy = 1'b0;
      i_exe_done = 1'b0; i_tx_done = 1'b0;
      clr_prev = 0; eng_busy = 0; eng_start = 0; tx_busy = 0;
      eng_cnt = 0; tx_cnt = 0; tx_resp = '0;
      rdy_mode = 0; done_en = 0; done_max = 0; tx_hold = 1; tx_max = 0;
      n_push = 0; n_drop = 0;

      #3;
      chk("rst_q_cnt", o_q_cnt, 0);
      chk("rst_exe_vld", o_exe_vld, 0);
      chk("rst_exe_cmd", o_exe_cmd, 0);
      chk("rst_trmt", o_trmt, 0);
      chk("rst_resp", o_resp, 0);
      chk("rst_clr", o_clr_cmd_rdy, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();

      // 1: single command, cmd_rdy held two cycles, one ACK, no repeat while tx stalls
      rdy_mode = 1;
      i_cmd = 16'h2345; i_cmd_rdy = 1'b1;
      tick();
      chk("t1_vld_early", o_exe_vld, 0);
      tick();
      i_cmd_rdy = 1'b0;
      chk("t1_vld", o_exe_vld, 1);
      chk("t1_cmd", o_exe_cmd, 16'h2345);
      done_en = 1; done_max = 2;
      wait_resp(1, 20, "t1_ack_seen");
      chk("t1_ack", got[0], ACK);
      repeat (20) tick();
      chk("t1_single_trmt", got.size(), 1);
      tx_hold = 0;
      repeat (5) tick();
      chk("t1_issued", issued.size(), 1);
      clear_logs();

      // 2: overflow with engine stalled, then in-order issue
      rdy_mode = 0; tx_max = 1;
      for (int i = 1; i <= 5; i++) send(16'h1000 + 16'(i), 1);
      chk("t2_q_full", o_q_cnt, 4);
      wait_resp(1, 20, "t2_nak_seen");
      chk("t2_nak", got[0], NAK);
      rdy_mode = 1;
      repeat (60) tick();
      chk("t2_issued_n", issued.size(), 4);
      for (int i = 0; i < issued.size(); i++) chk("t2_order", issued[i], 16'h1001 + 16'(i));
      chk("t2_resp_n", got.size(), 5);
      clear_logs();

      // 3: flush while a command is held in issue
      rdy_mode = 0;
      for (int i = 1; i <= 3; i++) send(16'h3000 + 16'(i), 1);
      chk("t3_vld_held", o_exe_vld, 1);
      send(16'h0000, 0);
      chk("t3_q_empty", o_q_cnt, 0);
      chk("t3_vld_drop", o_exe_vld, 0);
      rdy_mode = 1;
      repeat (30) tick();
      chk("t3_none_issued", issued.size(), 0);
      chk("t3_resp_n", got.size(), 1);
      chk("t3_ack", got[0], ACK);
      clear_logs();

      // 4: completion and overflow drop in the same cycle
      rdy_mode = 1; done_en = 0; tx_hold = 1;
      send(16'h4001, 3);
      chk("t4_accepted", issued.size(), 1);
      rdy_mode = 0;
      for (int i = 2; i <= 5; i++) send(16'h4000 + 16'(i), 1);
      chk("t4_q_full", o_q_cnt, 4);
      i_cmd = 16'h4006; i_cmd_rdy = 1'b1; i_exe_done = 1'b1;
      tick();
      i_cmd_rdy = 1'b0;
      wait_resp(1, 10, "t4_first_seen");
      repeat (10) tick();
      chk("t4_gated", got.size(), 1);
      chk("t4_first_ack", got[0], ACK);
      tx_hold = 0;
      wait_resp(2, 20, "t4_second_seen");
      chk("t4_second_nak", got[1], NAK);
      rdy_mode = 1; done_en = 1;
      repeat (60) tick();
      chk("t4_issued_n", issued.size(), 5);
      chk("t4_resp_n", got.size(), 6);
      clear_logs();

      // 5: nine completions with tx stalled: one sent, eight pending saturate to seven
      rdy_mode = 1; done_en = 1; done_max = 0; tx_hold = 1; tx_max = 0;
      for (int i = 0; i < 9; i++) send(16'h5001 + 16'(i), 3);
      repeat (20) tick();
      chk("t5_issued_n", issued.size(), 9);
      chk("t5_stalled", got.size(), 1);
      tx_hold = 0;
      repeat (60) tick();
      chk("t5_total", got.size(), 8);
      for (int i = 0; i < got.size(); i++) chk("t5_ack", got[i], ACK);
      clear_logs();

      // 6: asynchronous reset while busy with two queued
      rdy_mode = 1; done_en = 0;
      send(16'h6001, 3);
      rdy_mode = 0;
      send(16'h6002, 1);
      send(16'h6003, 1);
      chk("t6_pre_q", o_q_cnt, 2);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_q_cnt", o_q_cnt, 0);
      chk("t6_exe_vld", o_exe_vld, 0);
      chk("t6_exe_cmd", o_exe_cmd, 0);
      chk("t6_trmt", o_trmt, 0);
      chk("t6_resp", o_resp, 0);
      exp_fifo.delete();
      eng_busy = 0; eng_start = 0; tx_busy = 0; clr_prev = 0;
      repeat (2) tick();
      rst_n = 1'b1;
      clear_logs();
      i_exe_done = 1'b1;
      tick();
      rdy_mode = 1; done_en = 1;
      repeat (30) tick();
      chk("t6_no_resp", got.size(), 0);
      chk("t6_no_issue", issued.size(), 0);
      clear_logs();

      // 7: random traffic against the queue model
      rdy_mode = 2; done_en = 1; done_max = 4; tx_hold = 0; tx_max = 1;
      for (int i = 0; i < 40; i++)
         send({4'($urandom_range(15, 1)), 12'($urandom)}, $urandom_range(7, 4));
      repeat (100) tick();
      chk("t7_issued_n", issued.size(), pushed_ord.size());
      for (int i = 0; i < issued.size() && i < pushed_ord.size(); i++)
         chk("t7_order", issued[i], pushed_ord[i]);
      na5 = 0; n5a = 0;
      foreach (got[i]) begin
         if (got[i] == ACK) na5++;
         else if (got[i] == NAK) n5a++;
      end
      chk("t7_acks", na5, n_push);
      chk("t7_naks", n5a, n_drop);
      chk("t7_resp_n", got.size(), n_push + n_drop);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
